// File: rtl/rsa_modexp_box.sv
// rsa_modexp_box: Avalon-MM register box with a constant-time modular
// exponentiation engine computing R = B^E mod N (right-to-left binary method).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   chipselect, write bus select and direction (1 = write)
//   address           word address: 0 CTRL/STATUS, then B, E, N, R words
//   data_in           write data
//   data_out          registered read data (valid one cycle after the read)
//   irq               level interrupt, high while done && irq_en
module rsa_modexp_box #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam int NW = KEY_W / DATA_W;
    localparam int CW = $clog2(KEY_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Software-visible operand and result registers
    logic [KEY_W-1:0] r_b;
    logic [KEY_W-1:0] r_e;
    logic [KEY_W-1:0] r_n;
    logic [KEY_W-1:0] r_res;

    // Engine state: running result r, running square b, exponent copy
    logic [KEY_W-1:0] r_r;
    logic [KEY_W-1:0] r_bb;
    logic [KEY_W-1:0] r_ex;
    // Multiplier shift copies, scanned MSB first
    logic [KEY_W-1:0] r_m0;
    logic [KEY_W-1:0] r_m1;
    // Two extra bits hold the pre-reduction value 2*acc + a < 3N
    logic [KEY_W+1:0] r_acc0;
    logic [KEY_W+1:0] r_acc1;
    logic [CW-1:0]    r_j;
    logic [CW-1:0]    r_i;

    logic r_done;
    logic r_err;
    logic r_irq_en;

    logic              w_busy;
    logic              w_ctrl_wr;
    logic              w_reg_wr;
    logic              w_start;
    logic              w_abort;
    logic              w_clear;
    logic              w_bad;
    logic              w_last_bit;
    logic              w_last_exp;
    logic [KEY_W-1:0]  w_rnext;
    logic [KEY_W+1:0]  w_p0;
    logic [KEY_W+1:0]  w_p1;
    logic [DATA_W-1:0] w_rdata;

    // One Blakley step: acc' = 2*acc + bit*a, then up to two subtractions
    // of N bring it back below N (inputs satisfy acc < N and a < N).
    function automatic logic [KEY_W+1:0] blakley_step(
        input logic [KEY_W+1:0] acc,
        input logic [KEY_W-1:0] mcand,
        input logic             mbit,
        input logic [KEY_W-1:0] n
    );
        logic [KEY_W+1:0] s;
        logic [KEY_W+1:0] nn;
        nn = {2'b00, n};
        s  = acc + acc + (mbit ? {2'b00, mcand} : '0);
        if (s >= nn) s = s - nn;
        if (s >= nn) s = s - nn;
        return s;
    endfunction

    assign w_busy     = (r_state != S_IDLE);
    assign w_ctrl_wr  = chipselect & write & (address == '0);
    assign w_reg_wr   = chipselect & write & ~w_busy;
    assign w_abort    = w_ctrl_wr & data_in[1];
    assign w_start    = w_ctrl_wr & data_in[0] & ~data_in[1];
    assign w_clear    = w_ctrl_wr & data_in[3];
    assign w_bad      = (r_n <= KEY_W'(1)) || (r_b >= r_n);
    assign w_last_bit = (r_j == CW'(KEY_W - 1));
    assign w_last_exp = (r_i == CW'(KEY_W - 1));

    assign w_p0    = blakley_step(r_acc0, r_bb, r_m0[KEY_W-1], r_n);
    assign w_p1    = blakley_step(r_acc1, r_bb, r_m1[KEY_W-1], r_n);
    assign w_rnext = r_ex[0] ? r_acc0[KEY_W-1:0] : r_r;

    assign irq = r_done & r_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = w_bad ? S_IDLE : S_RUN;
            S_RUN:    if (w_last_bit) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = w_last_exp ? S_DONE : S_RUN;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_rdata = '0;
        if (address == '0)
            w_rdata = {{(DATA_W-4){1'b0}}, r_irq_en, r_err, r_done, w_busy};
        for (int k = 0; k < NW; k++) begin
            if (address == ADDR_W'(1 + k))
                w_rdata = r_b[k*DATA_W +: DATA_W];
            if (address == ADDR_W'(1 + NW + k))
                w_rdata = r_e[k*DATA_W +: DATA_W];
            if (address == ADDR_W'(1 + 2*NW + k))
                w_rdata = r_n[k*DATA_W +: DATA_W];
            if (address == ADDR_W'(1 + 3*NW + k))
                w_rdata = r_res[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b      <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_res    <= '0;
            r_r      <= '0;
            r_bb     <= '0;
            r_ex     <= '0;
            r_m0     <= '0;
            r_m1     <= '0;
            r_acc0   <= '0;
            r_acc1   <= '0;
            r_j      <= '0;
            r_i      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_irq_en <= 1'b0;
            data_out <= '0;
        end else begin
            if (w_reg_wr) begin
                for (int k = 0; k < NW; k++) begin
                    if (address == ADDR_W'(1 + k))
                        r_b[k*DATA_W +: DATA_W] <= data_in;
                    if (address == ADDR_W'(1 + NW + k))
                        r_e[k*DATA_W +: DATA_W] <= data_in;
                    if (address == ADDR_W'(1 + 2*NW + k))
                        r_n[k*DATA_W +: DATA_W] <= data_in;
                end
            end

            if (w_ctrl_wr) r_irq_en <= data_in[2];

            if (chipselect && !write) data_out <= w_rdata;

            if (!w_abort) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_done <= 1'b0;
                            r_err  <= 1'b0;
                        end
                    end
                    S_CHECK: begin
                        if (w_bad) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                            r_res  <= '0;
                        end else begin
                            r_r    <= KEY_W'(1);
                            r_bb   <= r_b;
                            r_m0   <= KEY_W'(1);
                            r_m1   <= r_b;
                            r_ex   <= r_e;
                            r_acc0 <= '0;
                            r_acc1 <= '0;
                            r_j    <= '0;
                            r_i    <= '0;
                        end
                    end
                    S_RUN: begin
                        r_acc0 <= w_p0;
                        r_acc1 <= w_p1;
                        r_m0   <= r_m0 << 1;
                        r_m1   <= r_m1 << 1;
                        r_j    <= r_j + CW'(1);
                    end
                    S_COMMIT: begin
                        // Both products are always formed; only the
                        // select depends on the exponent bit.
                        r_r    <= w_rnext;
                        r_bb   <= r_acc1[KEY_W-1:0];
                        r_m0   <= w_rnext;
                        r_m1   <= r_acc1[KEY_W-1:0];
                        r_ex   <= r_ex >> 1;
                        r_acc0 <= '0;
                        r_acc1 <= '0;
                        r_j    <= '0;
                        r_i    <= r_i + CW'(1);
                        if (w_last_exp) r_res <= w_rnext;
                    end
                    S_DONE: begin
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_clear) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_abort) r_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_box.sv
// tb_rsa_modexp_box: directed bench for rsa_modexp_box with a 32-bit
// and a 128-bit instance sharing the clock and bus data/address lines.
module tb_rsa_modexp_box;

    logic        clk;
    logic        rst32_n;
    logic        rst128_n;
    logic        cs32;
    logic        cs128;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout32;
    logic [31:0] dout128;
    logic        irq32;
    logic        irq128;

    int n_chk;
    int n_fail;
    int cyc;
    int last_wr_cyc;

    rsa_modexp_box #(.DATA_W(32), .KEY_W(32), .ADDR_W(5)) dut32 (
        .clk(clk), .reset_n(rst32_n), .chipselect(cs32), .write(wr),
        .address(addr), .data_in(din), .data_out(dout32), .irq(irq32)
    );

    rsa_modexp_box #(.DATA_W(32), .KEY_W(128), .ADDR_W(5)) dut128 (
        .clk(clk), .reset_n(rst128_n), .chipselect(cs128), .write(wr),
        .address(addr), .data_in(din), .data_out(dout128), .irq(irq128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] b;
        logic [127:0] e;
        logic [127:0] n;
        logic [127:0] r;
        bit           err;
        string        nm;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input bit s, input int a, input logic [31:0] d);
        @(negedge clk);
        cs32  = !s;
        cs128 = s;
        wr    = 1'b1;
        addr  = 5'(a);
        din   = d;
        @(negedge clk);
        cs32  = 1'b0;
        cs128 = 1'b0;
        wr    = 1'b0;
        last_wr_cyc = cyc;
    endtask

    task automatic bus_rd(input bit s, input int a, output logic [31:0] d);
        @(negedge clk);
        cs32  = !s;
        cs128 = s;
        wr    = 1'b0;
        addr  = 5'(a);
        @(negedge clk);
        cs32  = 1'b0;
        cs128 = 1'b0;
        d = s ? dout128 : dout32;
    endtask

    task automatic wait_done(input bit s, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if ((s ? irq128 : irq32) === 1'b1) got = 1'b1;
        end
    endtask

    task automatic load_ops(input bit s, input logic [127:0] b,
                            input logic [127:0] e, input logic [127:0] n);
        int nw;
        nw = s ? 4 : 1;
        for (int k = 0; k < nw; k++) begin
            bus_wr(s, 1 + k, b[k*32 +: 32]);
            bus_wr(s, 1 + nw + k, e[k*32 +: 32]);
            bus_wr(s, 1 + 2*nw + k, n[k*32 +: 32]);
        end
    endtask

    task automatic read_r(input bit s, output logic [127:0] r);
        int nw;
        logic [31:0] w;
        nw = s ? 4 : 1;
        r = '0;
        for (int k = 0; k < nw; k++) begin
            bus_rd(s, 1 + 3*nw + k, w);
            r[k*32 +: 32] = w;
        end
    endtask

    task automatic run_vec(input bit s, input vec_t v);
        int kw;
        int lat_exp;
        int st;
        int lat;
        bit got;
        logic [31:0] w;
        logic [127:0] r;
        kw = s ? 128 : 32;
        lat_exp = 2 + kw * (kw + 1);
        load_ops(s, v.b, v.e, v.n);
        bus_wr(s, 0, 32'h5);
        st = last_wr_cyc;
        wait_done(s, lat_exp + 20, got);
        lat = cyc - st;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles",
                     v.nm, lat_exp + 20);
        end else if (v.err) begin
            n_chk++;
            if (lat < 1 || lat > 3) begin
                n_fail++;
                $display("FAIL %s err latency: got %0d expected 1..3",
                         v.nm, lat);
            end
        end else begin
            chk({v.nm, " latency"}, 128'(lat), 128'(lat_exp));
        end
        bus_rd(s, 0, w);
        chk({v.nm, " status"}, 128'(w), 128'(v.err ? 32'hE : 32'hA));
        read_r(s, r);
        chk({v.nm, " result"}, r, v.r);
    endtask

    initial begin
        logic [31:0] w;
        logic [127:0] r;
        int st;
        int lat;
        bit got;
        vec_t v;

        tbl[0] = '{128'd4, 128'd13, 128'd497, 128'd445, 1'b0, "t4_13_497"};
        tbl[1] = '{128'd5, 128'd0, 128'd7, 128'd1, 1'b0, "e_zero"};
        tbl[2] = '{128'd0, 128'd5, 128'd1, 128'd0, 1'b1, "n_one"};
        tbl[3] = '{128'd3233, 128'd3, 128'd3233, 128'd0, 1'b1, "b_eq_n"};
        tbl[4] = '{128'd2, 128'd10, 128'd1000, 128'd24, 1'b0, "even_n"};
        tbl[5] = '{128'd7, 128'hFFFFFFFF, 128'd13, 128'd5, 1'b0, "e_ones"};
        tbl[6] = '{128'd496, 128'd2, 128'd497, 128'd1, 1'b0, "b_nm1"};
        tbl[7] = '{128'd0, 128'd5, 128'd10, 128'd0, 1'b0, "b_zero"};
        tbl[8] = '{128'hFFFFFFFA, 128'd3, 128'hFFFFFFFB, 128'hFFFFFFFA,
                   1'b0, "wide_n"};
        tbl[9] = '{128'd2, 128'd33, 128'hFFFFFFFF, 128'd2, 1'b0, "n_max"};

        n_chk = 0;
        n_fail = 0;
        rst32_n = 1'b0;
        rst128_n = 1'b0;
        cs32 = 1'b0;
        cs128 = 1'b0;
        wr = 1'b0;
        addr = '0;
        din = '0;
        repeat (3) @(negedge clk);
        rst32_n = 1'b1;
        rst128_n = 1'b1;
        @(negedge clk);

        chk("reset dout32", 128'(dout32), 128'd0);
        chk("reset dout128", 128'(dout128), 128'd0);
        chk("reset irq32", 128'(irq32), 128'd0);
        chk("reset irq128", 128'(irq128), 128'd0);
        bus_rd(0, 0, w);
        chk("reset status32", 128'(w), 128'd0);
        bus_rd(1, 0, w);
        chk("reset status128", 128'(w), 128'd0);

        foreach (tbl[i]) run_vec(0, tbl[i]);

        bus_rd(0, 31, w);
        chk("unmapped read", 128'(w), 128'd0);
        bus_rd(0, 2, w);
        chk("e readback", 128'(w), 128'd33);

        // Writes and restarts while busy must not disturb the run
        load_ops(0, 128'd4, 128'd13, 128'd497);
        bus_wr(0, 0, 32'h5);
        st = last_wr_cyc;
        repeat (100) @(negedge clk);
        bus_wr(0, 1, 32'd9);
        bus_wr(0, 0, 32'h5);
        bus_rd(0, 1, w);
        chk("busy b write ignored", 128'(w), 128'd4);
        wait_done(0, 1100, got);
        lat = cyc - st;
        chk("busy run done", 128'(got), 128'd1);
        chk("busy restart latency", 128'(lat), 128'd1058);
        read_r(0, r);
        chk("busy run result", r, 128'd445);

        // Read data lands exactly one edge after the read cycle
        @(negedge clk);
        cs32 = 1'b1;
        wr = 1'b0;
        addr = 5'd2;
        #1;
        chk("read before edge", 128'(dout32), 128'd445);
        @(negedge clk);
        cs32 = 1'b0;
        chk("read after edge", 128'(dout32), 128'd13);
        @(negedge clk);
        chk("read hold", 128'(dout32), 128'd13);

        chk("irq before clear", 128'(irq32), 128'd1);
        bus_wr(0, 0, 32'hC);
        chk("irq after clear", 128'(irq32), 128'd0);
        bus_rd(0, 0, w);
        chk("status after clear", 128'(w), 128'd8);

        // Abort halfway; start in the same write must lose
        load_ops(0, 128'd2, 128'd10, 128'd1000);
        bus_wr(0, 0, 32'h1);
        repeat (520) @(negedge clk);
        bus_rd(0, 0, w);
        chk("busy mid run", 128'(w), 128'd1);
        bus_wr(0, 0, 32'h7);
        bus_rd(0, 0, w);
        chk("status after abort", 128'(w), 128'd8);
        read_r(0, r);
        chk("r kept on abort", r, 128'd445);
        repeat (1200) @(negedge clk);
        chk("no irq after abort", 128'(irq32), 128'd0);
        bus_rd(0, 0, w);
        chk("status idle after abort", 128'(w), 128'd8);

        // Asynchronous reset in the middle of a run
        load_ops(0, 128'd4, 128'd13, 128'd497);
        bus_wr(0, 0, 32'h5);
        repeat (300) @(negedge clk);
        rst32_n = 1'b0;
        #1;
        chk("mid reset dout", 128'(dout32), 128'd0);
        chk("mid reset irq", 128'(irq32), 128'd0);
        @(negedge clk);
        rst32_n = 1'b1;
        bus_rd(0, 0, w);
        chk("mid reset status", 128'(w), 128'd0);
        read_r(0, r);
        chk("mid reset r", r, 128'd0);
        bus_rd(0, 1, w);
        chk("mid reset b", 128'(w), 128'd0);
        run_vec(0, tbl[0]);

        v = '{128'd0, 128'd5, 128'd1, 128'd0, 1'b1, "w128_n_one"};
        run_vec(1, v);
        v = '{128'd3233, 128'd3, 128'd3233, 128'd0, 1'b1, "w128_b_eq_n"};
        run_vec(1, v);
        v = '{128'd65, 128'd17, 128'd3233, 128'd2790, 1'b0, "rsa_encrypt"};
        run_vec(1, v);
        v = '{128'd2790, 128'd413, 128'd3233, 128'd65, 1'b0, "rsa_decrypt"};
        run_vec(1, v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
